// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the 3x3 convolution sequencer
package conv_pkg;

    localparam int DATA_W = 8;
    localparam int TAPS   = 9;
    localparam int KERNEL = 3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RUN  = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/eight_bit_full_adder_module.sv
// rtl/eight_bit_full_adder_module.sv - 8-bit ripple adder, sum wraps mod 256
module eight_bit_full_adder_module (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum
);

    logic carry;

    // Ripple the carry bit by bit; the carry out of bit 7 is dropped so the sum wraps
    always_comb begin
        carry = cin;
        sum   = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
    end

endmodule

// File: rtl/mac8_unit.sv
// rtl/mac8_unit.sv - 8x8 multiply truncated to 8 bits with wrapping 8-bit accumulator
module mac8_unit
    import conv_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc
);

    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] sum;

    // Multiply in an 8-bit context so only the low byte of the product is kept
    assign prod = a * b;

    eight_bit_full_adder_module u_add (
        .a   (acc),
        .b   (prod),
        .cin (1'b0),
        .sum (sum)
    );

    // Accumulator register; clear wins so a new window never inherits a stale sum
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= sum;
        end
    end

endmodule

// File: rtl/conv3x3_seq_ctrl.sv
// rtl/conv3x3_seq_ctrl.sv - window sequencer driving the MAC through 3x3 convolution taps
module conv3x3_seq_ctrl
    import conv_pkg::*;
#(
    parameter int IMG_W  = 4,
    parameter int IMG_H  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              pix_rd_en,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [3:0]        wgt_addr,
    input  logic [DATA_W-1:0] pix_data,
    input  logic [DATA_W-1:0] wgt_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              done
);

    localparam logic [ADDR_W-1:0] IMG_W_A  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 3);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 3);
    localparam logic [3:0]        TAP_LAST = 4'(TAPS - 1);
    localparam logic [1:0]        K_LAST   = 2'(KERNEL - 1);

    state_t            state;
    state_t            next_state;
    logic [ADDR_W-1:0] row;
    logic [ADDR_W-1:0] col;
    logic [3:0]        tap;
    logic [1:0]        kx;
    logic [1:0]        ky;
    logic              rd_d1;
    logic [DATA_W-1:0] acc;
    logic [ADDR_W-1:0] tap_addr;

    logic frame_go;
    logic accept;
    logic last_win;
    logic win_go;
    logic tap_last;

    assign frame_go = (state == ST_IDLE) && start;
    assign accept   = (state == ST_OUT) && out_ready;
    assign last_win = (col == COL_LAST) && (row == ROW_LAST);
    assign win_go   = accept && !last_win;
    assign tap_last = (tap == TAP_LAST);
    assign tap_addr = (row + ADDR_W'(ky)) * IMG_W_A + col + ADDR_W'(kx);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: nine reads, one drain cycle, then hold the result until accepted
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start)    next_state = ST_RUN;
            ST_RUN:  if (tap_last) next_state = ST_WAIT;
            ST_WAIT:               next_state = ST_OUT;
            ST_OUT:  if (accept)   next_state = last_win ? ST_DONE : ST_RUN;
            ST_DONE:               next_state = ST_IDLE;
            default:               next_state = ST_IDLE;
        endcase
    end

    // Outputs decoded from state; address lines are parked at zero outside RUN
    always_comb begin
        busy      = 1'b0;
        pix_rd_en = 1'b0;
        pix_addr  = '0;
        wgt_addr  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        done      = 1'b0;
        case (state)
            ST_RUN: begin
                busy      = 1'b1;
                pix_rd_en = 1'b1;
                pix_addr  = tap_addr;
                wgt_addr  = tap;
            end
            ST_WAIT: busy = 1'b1;
            ST_OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = acc;
            end
            ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    // Tap and window position counters; kx/ky step alongside tap so no divider is needed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
            tap <= '0;
            kx  <= '0;
            ky  <= '0;
        end else begin
            if (frame_go) begin
                row <= '0;
                col <= '0;
                tap <= '0;
                kx  <= '0;
                ky  <= '0;
            end else if (state == ST_RUN) begin
                if (tap_last) begin
                    tap <= '0;
                    kx  <= '0;
                    ky  <= '0;
                end else begin
                    tap <= tap + 4'd1;
                    if (kx == K_LAST) begin
                        kx <= '0;
                        ky <= ky + 2'd1;
                    end else begin
                        kx <= kx + 2'd1;
                    end
                end
            end
            if (win_go) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= row + ADDR_W'(1);
                end else begin
                    col <= col + ADDR_W'(1);
                end
            end
        end
    end

    // Memory read data lands one cycle after the strobe, so accumulate on the delayed strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_d1 <= 1'b0;
        end else begin
            rd_d1 <= pix_rd_en;
        end
    end

    mac8_unit u_mac (
        .clk (clk),
        .rst (rst),
        .clr (frame_go || win_go),
        .en  (rd_d1),
        .a   (pix_data),
        .b   (wgt_data),
        .acc (acc)
    );

endmodule

// File: doc/conv3x3_seq_ctrl.md
Name: conv3x3_seq_ctrl

Overview:
Sequencer that drives the 8-bit multiply-accumulate path through 3x3 convolution windows over an image held in external synchronous pixel and weight memories.
For each valid (unpadded) output position it issues nine tap reads, multiplies and accumulates modulo 256, and presents the 8-bit result on a valid/ready output.
It sits between the frame-start control logic and the downstream result buffer, replacing free-running count-to-9 accumulation with explicit window sequencing and backpressure.

Parameters:
IMG_W, 4, image width in pixels (>=3)
IMG_H, 4, image height in pixels (>=3)
ADDR_W, 8, pixel memory address width (IMG_W*IMG_H <= 2**ADDR_W)

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
start  input  1  begin a frame; sampled only in IDLE
busy  output  1  high from the cycle after accepted start until DONE completes
pix_rd_en  output  1  pixel/weight read strobe
pix_addr  output  ADDR_W  pixel address = (row+ky)*IMG_W + (col+kx)
wgt_addr  output  4  weight tap index 0..8 = ky*3+kx
pix_data  input  8  pixel memory read data, valid 1 cycle after pix_rd_en
wgt_data  input  8  weight memory read data, valid 1 cycle after pix_rd_en
out_valid  output  1  result available
out_ready  input  1  downstream accepts result
out_data  output  8  window sum mod 256
done  output  1  one-cycle pulse after last result accepted

Behaviour:
- Reset (async): state IDLE; row=col=tap=0; acc=0; rd_d1=0. All outputs 0.
- States: IDLE, RUN, WAIT, OUT, DONE.
- IDLE: start=1 -> RUN, row=col=0, tap=0, acc=0. start=0 -> stay.
- start outside IDLE: ignored, no effect on sequencing.
- RUN: pix_rd_en=1 every cycle; tap increments 0..8; kx=tap%3, ky=tap/3 (counters, no divider). After tap 8 -> WAIT.
- rd_d1 = registered pix_rd_en. When rd_d1=1: acc <= acc + (pix_data*wgt_data)[7:0]. Product truncated to low 8 bits; sum wraps mod 256; no saturation, no carry out.
- acc is cleared on the transition into RUN, never mid-window.
- WAIT: one cycle, no read; the tap-8 product is accumulated in this cycle. -> OUT.
- OUT: out_valid=1, out_data=acc; both held stable until out_valid&&out_ready. No reads are issued while in OUT.
- Handshake accepted:
  - if col==IMG_W-3 and row==IMG_H-3 -> DONE;
  - else advance col (wrap to 0 with row+1 at IMG_W-3) -> RUN with tap=0, acc=0.
- Accept and out_valid drop occur in the same cycle boundary; no double accept.
- DONE: done=1 for exactly one cycle, busy=0, -> IDLE. A start in the DONE cycle is ignored.
- busy=1 in RUN, WAIT, OUT.
- Per-window latency:
  - 9 RUN + 1 WAIT cycles, then out_valid;
  - minimum 11 cycles per window with out_ready held 1.
- Outputs: (IMG_W-2)*(IMG_H-2) results, raster order.
- Reset mid-frame: immediately returns to IDLE values. Partial sums are discarded and no result or done is emitted.
- out_ready while out_valid=0: no effect.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, RUN, WAIT, OUT, DONE);
  - TAPS=9, KERNEL=3 constants;
  - 8-bit data width constant.
- Sub-module mac8_unit: 8x8 multiply truncate to 8 bits plus 8-bit accumulate register with clear/enable. It wraps the existing eight_bit_full_adder_module for the add.
- Controller FSM and address counters stay in conv3x3_seq_ctrl.

Test Plan:
- Address order: 4x4 image, start pulse -> first window pix_addr 0,1,2,4,5,6,8,9,10 with wgt_addr 0..8 on consecutive cycles; fourth window starts at addr 5.
- Basic sum: all pixels 1, weights 1, out_ready=1 -> four results of 9; out_valid first high 11 cycles after start; done pulses once after 4th accept.
- Wrap arithmetic:
  - pixels 10, weights 3 -> each result 270 mod 256 = 14;
  - pixels 16, weights 16 -> product truncates to 0, result 0.
- Backpressure: out_ready low 5 cycles on first result -> out_valid and out_data (9) held stable, pix_rd_en stays 0, sequence resumes correctly after accept.
- start while busy: pulse start mid-frame -> no restart, still exactly 4 results and one done.
- Reset mid-window: assert rst during tap 4 of window 2 -> all outputs 0, IDLE. A new start then produces a full correct 4-result frame.
